// File: rtl/shift_sched_amisha_pkg.sv
// shift_sched_pkg_amisha: shared types and default widths for the rotate sequencer
// Holds the FSM state encoding, default DATA_W/AMT_W/REP_W and rotate direction codes.
package shift_sched_pkg_amisha;
    localparam int DATA_W = 8;
    localparam int AMT_W  = 3;
    localparam int REP_W  = 4;
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/shift_sched_amisha_rot.sv
// rot_unit_amisha: combinational DATA_W rotator shared by both requesters
// Ports: data (operand), amt (rotate amount), dir (0 left / 1 right), out (rotated word).
module rot_unit_amisha
    import shift_sched_pkg_amisha::*;
#(
    parameter int DATA_W = shift_sched_pkg_amisha::DATA_W,
    parameter int AMT_W  = shift_sched_pkg_amisha::AMT_W
) (
    input  logic [DATA_W-1:0] data,
    input  logic [AMT_W-1:0]  amt,
    input  logic              dir,
    output logic [DATA_W-1:0] out
);
    logic [2*DATA_W-1:0] dd;
    // A window into the doubled word is a rotate in either direction.
    always_comb begin
        dd  = {data, data};
        out = (dir == DIR_RIGHT) ? dd[int'(amt) +: DATA_W] : dd[DATA_W - int'(amt) +: DATA_W];
    end
endmodule

// File: rtl/shift_sched_amisha.sv
// shift_sched_amisha: round-robin sequencer for two requesters over a shared rotate datapath
// Ports: clk_amisha/reset_amisha (sync active-high); req0_*/req1_* command valid/ready with
// data, amt, dir, rep; res_valid/res_ready/res_data/res_id result handshake.
// Define SHIFT_SCHED_STAT_EN to add stat_done_cnt, a saturating count of result handshakes.
module shift_sched_amisha
    import shift_sched_pkg_amisha::*;
#(
    parameter int DATA_W = shift_sched_pkg_amisha::DATA_W,
    parameter int AMT_W  = shift_sched_pkg_amisha::AMT_W,
    parameter int REP_W  = shift_sched_pkg_amisha::REP_W
) (
    input  logic              clk_amisha,
    input  logic              reset_amisha,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [AMT_W-1:0]  req0_amt,
    input  logic              req0_dir,
    input  logic [REP_W-1:0]  req0_rep,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [AMT_W-1:0]  req1_amt,
    input  logic              req1_dir,
    input  logic [REP_W-1:0]  req1_rep,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_id
`ifdef SHIFT_SCHED_STAT_EN
    ,
    output logic [15:0]       stat_done_cnt
`endif
);
    state_t state, state_nx;
    logic [DATA_W-1:0] data_q, rot_out;
    logic [AMT_W-1:0]  amt_q;
    logic [REP_W-1:0]  cnt_q, sel_rep;
    logic              dir_q, id_q, rr_ptr, acc, sel;

    rot_unit_amisha #(.DATA_W(DATA_W), .AMT_W(AMT_W)) u_rot (
        .data(data_q),
        .amt (amt_q),
        .dir (dir_q),
        .out (rot_out)
    );

    // A requester loses only when the other is also valid and holds the round-robin pointer.
    always_comb begin
        req0_ready = (state == IDLE) && req0_valid && !(req1_valid && rr_ptr);
        req1_ready = (state == IDLE) && req1_valid && !(req0_valid && !rr_ptr);
        acc        = req0_ready || req1_ready;
        sel        = req1_ready;
        sel_rep    = sel ? req1_rep : req0_rep;
        state_nx   = (state == IDLE && acc) ? ((sel_rep == '0) ? DONE : RUN) :
                     (state == RUN && cnt_q == REP_W'(1)) ? DONE :
                     (state == DONE && res_ready) ? IDLE : state;
        res_valid  = (state == DONE);
        res_data   = data_q;
        res_id     = id_q;
    end

    always_ff @(posedge clk_amisha) begin
        if (reset_amisha) begin
            state  <= IDLE;
            data_q <= '0;
            amt_q  <= '0;
            dir_q  <= DIR_LEFT;
            cnt_q  <= '0;
            id_q   <= 1'b0;
            rr_ptr <= 1'b0;
        end else begin
            state <= state_nx;
            if (acc) begin
                data_q <= sel ? req1_data : req0_data;
                amt_q  <= sel ? req1_amt : req0_amt;
                dir_q  <= sel ? req1_dir : req0_dir;
                cnt_q  <= sel_rep;
                id_q   <= sel;
                rr_ptr <= ~sel;
            end else if (state == RUN) begin
                data_q <= rot_out;
                cnt_q  <= cnt_q - REP_W'(1);
            end
        end
    end

`ifdef SHIFT_SCHED_STAT_EN
    always_ff @(posedge clk_amisha) begin
        if (reset_amisha)
            stat_done_cnt <= '0;
        else if (res_valid && res_ready && stat_done_cnt != 16'hFFFF)
            stat_done_cnt <= stat_done_cnt + 16'd1;
    end
`endif
endmodule

// File: doc/shift_sched_amisha.md
Name: shift_sched_amisha

Overview:
Sequencing controller for the shared 8-bit rotate datapath. It arbitrates two requesters with a round-robin scheme and runs one command at a time. Each command may repeat a rotate of the datapath word several times, one rotate pass per clock. The block returns the result through a valid/ready handshake tagged with the requester id. It sits between the switch/button front-end and the LED output stage.

Parameters:
DATA_W, 8, width of data word
AMT_W, 3, width of rotate amount (0..DATA_W-1)
REP_W, 4, width of repeat count (0..15 passes)

Ports:
clk_amisha  in  1  single clock, rising edge
reset_amisha  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 command valid
req0_ready  out  1  requester 0 command accepted this cycle
req0_data  in  DATA_W  operand
req0_amt  in  AMT_W  rotate amount per pass
req0_dir  in  1  0 = rotate left, 1 = rotate right
req0_rep  in  REP_W  number of rotate passes
req1_valid / req1_ready / req1_data / req1_amt / req1_dir / req1_rep: same as requester 0, for requester 1
res_valid  out  1  result valid
res_ready  in  1  consumer accepts result
res_data  out  DATA_W  rotated result
res_id  out  1  id of the requester that issued the command

Behaviour:
- Clock and reset are decided: one clock (clk_amisha); reset_amisha is synchronous and active-high.
- States: IDLE, RUN, DONE.
- Reset values: state=IDLE, res_valid=0, res_data=0, res_id=0, rr_ptr=0, pass counter=0, req0_ready=0, req1_ready=0.
- Ready generation: reqN_ready is combinational and is high only in IDLE, only for the granted requester. At most one ready is high in any cycle.
- Grant rule:
  - only one valid: that requester wins.
  - both valid: the requester equal to rr_ptr wins.
- Accept happens on an edge where reqN_valid && reqN_ready. At that edge the block latches data, amt, dir, rep and id, and sets rr_ptr = ~id.
- IDLE transitions on accept:
  - rep==0: go to DONE; result = operand unchanged.
  - rep>0: go to RUN; counter = rep.
- RUN, each edge:
  - data <= rot(data, amt, dir).
  - counter decrements.
  - when counter==1 at the edge, go to DONE.
  - amt==0 is a legal no-op pass and still consumes a cycle.
- Latency: with accept at edge T, res_valid is high after edge T+rep (rep=0 gives valid after edge T).
- DONE:
  - res_valid=1; res_data and res_id are held stable while res_ready=0.
  - on edge with res_ready=1: go to IDLE, res_valid drops.
  - a new command is accepted no earlier than the cycle after that edge, so there is no accept in the DONE cycle.
- Rotation: modulo DATA_W; no bits are lost. Left: {d[W-1-a:0], d[W-1:W-a]}.
- Requester rule: fields must stay stable while valid is high and ready is low. A requester may drop valid before it is accepted; nothing is latched in that case.
- Reset in RUN or DONE: the command in flight is discarded and the block returns to reset values on that edge. Reset overrides a simultaneous accept or result handshake.

Optional Feature:
SHIFT_SCHED_STAT_EN
- Defined: adds output stat_done_cnt (16 bits). It increments on every result handshake, saturates at 0xFFFF, and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package shift_sched_pkg_amisha holds: state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2); DATA_W, AMT_W and REP_W defaults; DIR_LEFT=1'b0 and DIR_RIGHT=1'b1 constants.
- One sub-module, rot_unit_amisha: a combinational DATA_W rotator (data, amt, dir → out). It is instantiated once and shared by both requesters.

Test Plan:
- req0 data=0x05, amt=3, dir=0, rep=1 → res_data=0x28, res_id=0, res_valid high 1 cycle after the accept edge.
- req1 data=0x05, amt=3, dir=0, rep=2 → res_data=0x41 after 2 RUN cycles; data=0x1A, amt=2, dir=1, rep=1 → 0x86.
- req0 data=0x25, rep=0 → res_data=0x25 after the accept edge, with no RUN cycles.
- Both valid right after reset (rr_ptr=0) → req0 granted first (res_id=0); req1 granted next (res_id=1). With both valid again, req0 wins next.
- res_ready held low 5 cycles in DONE → res_valid and res_data stable; req0_ready and req1_ready stay 0; a single completion is seen after res_ready rises.
- Assert reset_amisha mid-RUN (rep=8) → next cycle state=IDLE, res_valid=0, rr_ptr=0; no result is emitted for the aborted command.
